svfloat_itof_arbiter: RTL and testbench

- Shares one combinational svfloat_itof converter among NREQ requesters.
- Each requester has a valid/ready integer request port; a round-robin arbiter picks one request per cycle.
- The request passes through a 2-stage registered pipeline (operand register, result register) with full backpressure.
- Results return on one shared valid/ready response port, tagged with the requester index.

---
 rtl/svfloat_pkg.sv | 32 +++
 rtl/svfloat_itof.sv | 61 ++++++
 rtl/svfloat_rr_arbiter.sv | 34 +++
 rtl/svfloat_itof_arbiter.sv | 125 ++++++++++++
 tb/tb_svfloat_itof_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/svfloat_pkg.sv
// Floating-point container types shared by the svfloat converters and schedulers.
// Formats are IEEE-754 style: sign, biased exponent, stored mantissa.
package svfloat;

    typedef struct packed {
        logic        sign;
        logic [4:0]  exp;
        logic [9:0]  mant;
    } float16;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } float32;

    typedef struct packed {
        logic        sign;
        logic [10:0] exp;
        logic [51:0] mant;
    } float64;

    // Exponent field width implied by a format's total width.
    function automatic int exp_bits(input int total_bits);
        case (total_bits)
            16:      return 5;
            64:      return 11;
            default: return 8;
        endcase
    endfunction

endpackage

// File: rtl/svfloat_itof.sv
// Combinational fixed-point integer to floating-point converter.
// Rounds to nearest-even; overflow saturates to infinity, underflow flushes to signed zero.
module svfloat_itof
    import svfloat::*;
#(
    parameter type float = svfloat::float32,
    parameter int  width = 32,
    parameter int  frac  = 0
) (
    input  logic [width-1:0]         in_data,
    input  logic                     in_signed,
    output logic [$bits(float)-1:0]  out_float
);

    localparam int FW   = $bits(float);
    localparam int EW   = exp_bits(FW);
    localparam int MW   = FW - 1 - EW;
    localparam int BIAS = (1 << (EW - 1)) - 1;
    localparam int EMAX = (1 << EW) - 1;
    localparam int XW   = width + MW + 1;

    logic             neg;
    logic [width-1:0] mag;
    logic [width-1:0] norm;
    logic [XW-1:0]    ext;
    logic [MW-1:0]    mant;
    logic [MW:0]      mant_rnd;
    logic             guard;
    logic             sticky;
    int               lead;
    int               expo;

    always_comb begin
        neg  = in_signed && in_data[width-1];
        mag  = neg ? -in_data : in_data;
        lead = 0;
        for (int i = 0; i < width; i++) begin
            if (mag[i]) lead = i;
        end
        // Left-justify so the hidden one sits at the top; padding leaves room for guard bits.
        norm     = mag << (width - 1 - lead);
        ext      = {norm, {(MW + 1){1'b0}}};
        mant     = ext[XW-2 -: MW];
        guard    = ext[XW-2-MW];
        sticky   = |ext[XW-3-MW:0];
        mant_rnd = {1'b0, mant} + {{MW{1'b0}}, guard && (sticky || mant[0])};
        expo     = lead - frac + BIAS + int'(mant_rnd[MW]);

        out_float = '0;
        if (mag == '0) begin
            out_float = '0;
        end else if (expo >= EMAX) begin
            out_float = {neg, {EW{1'b1}}, {MW{1'b0}}};
        end else if (expo > 0) begin
            out_float = {neg, expo[EW-1:0], mant_rnd[MW-1:0]};
        end else begin
            out_float = {neg, {(FW - 1){1'b0}}};
        end
    end

endmodule

// File: rtl/svfloat_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above ptr, wrapping.
// Shared by the svfloat schedulers; the caller owns and advances the pointer.
module svfloat_rr_arbiter #(
    parameter  int nreq = 4,
    localparam int idw  = (nreq > 1) ? $clog2(nreq) : 1
) (
    input  logic [nreq-1:0] req,
    input  logic            enable,
    input  logic [idw-1:0]  ptr,
    output logic [nreq-1:0] grant,
    output logic [idw-1:0]  grant_idx
);

    logic found;
    int   idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        if (enable) begin
            for (int k = 0; k < nreq; k++) begin
                idx = (int'(ptr) + k) % nreq;
                if (!found && req[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    grant_idx  = idw'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/svfloat_itof_arbiter.sv
// Shares one itof converter among nreq valid/ready requesters through a two-stage
// (operand, result) pipeline with full backpressure and an ID-tagged response port.
module svfloat_itof_arbiter
    import svfloat::*;
#(
    parameter  type float = svfloat::float32,
    parameter  int  width = 32,
    parameter  int  frac  = 0,
    parameter  int  nreq  = 4,
    localparam int  idw   = (nreq > 1) ? $clog2(nreq) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [nreq-1:0]         req_valid,
    output logic [nreq-1:0]         req_ready,
    input  logic [nreq*width-1:0]   req_data,
    input  logic [nreq-1:0]         req_signed,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [$bits(float)-1:0] resp_data,
    output logic [idw-1:0]          resp_id
);

    localparam int FW = $bits(float);

    logic             a_valid_q, a_valid_d;
    logic [width-1:0] a_data_q, a_data_d;
    logic             a_signed_q, a_signed_d;
    logic [idw-1:0]   a_id_q, a_id_d;
    logic             b_valid_q, b_valid_d;
    logic [FW-1:0]    b_data_q, b_data_d;
    logic [idw-1:0]   b_id_q, b_id_d;
    logic [idw-1:0]   rr_ptr_q, rr_ptr_d;

    logic             b_free;
    logic             a_adv;
    logic             a_free;
    logic             any_grant;
    logic [nreq-1:0]  grant;
    logic [idw-1:0]   grant_idx;
    logic [FW-1:0]    itof_result;

    svfloat_itof #(
        .float (float),
        .width (width),
        .frac  (frac)
    ) u_itof (
        .in_data   (a_data_q),
        .in_signed (a_signed_q),
        .out_float (itof_result)
    );

    // Arbitration only looks at pipeline occupancy, so resp_ready reaches req_ready via a_free alone.
    svfloat_rr_arbiter #(
        .nreq (nreq)
    ) u_arb (
        .req       (req_valid),
        .enable    (a_free && !rst),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        b_free    = !b_valid_q || resp_ready;
        a_adv     = a_valid_q && b_free;
        a_free    = !a_valid_q || a_adv;
        any_grant = |grant;
        req_ready = grant;

        a_valid_d  = a_valid_q;
        a_data_d   = a_data_q;
        a_signed_d = a_signed_q;
        a_id_d     = a_id_q;
        b_valid_d  = b_valid_q;
        b_data_d   = b_data_q;
        b_id_d     = b_id_q;
        rr_ptr_d   = rr_ptr_q;

        if (a_adv) begin
            b_valid_d = 1'b1;
            b_data_d  = itof_result;
            b_id_d    = a_id_q;
        end else if (b_valid_q && resp_ready) begin
            b_valid_d = 1'b0;
        end

        if (any_grant) begin
            a_valid_d  = 1'b1;
            a_data_d   = req_data[int'(grant_idx)*width +: width];
            a_signed_d = req_signed[grant_idx];
            a_id_d     = grant_idx;
            rr_ptr_d   = (grant_idx == idw'(nreq - 1)) ? '0 : grant_idx + 1'b1;
        end else if (a_adv) begin
            a_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid_q  <= 1'b0;
            a_data_q   <= '0;
            a_signed_q <= 1'b0;
            a_id_q     <= '0;
            b_valid_q  <= 1'b0;
            b_data_q   <= '0;
            b_id_q     <= '0;
            rr_ptr_q   <= '0;
        end else begin
            a_valid_q  <= a_valid_d;
            a_data_q   <= a_data_d;
            a_signed_q <= a_signed_d;
            a_id_q     <= a_id_d;
            b_valid_q  <= b_valid_d;
            b_data_q   <= b_data_d;
            b_id_q     <= b_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign resp_valid = b_valid_q;
    assign resp_data  = b_data_q;
    assign resp_id    = b_id_q;

endmodule

// File: tb/tb_svfloat_itof_arbiter.sv
// Directed and randomized checks of the shared itof arbiter: latency, sign/rounding,
// round-robin order, backpressure, mid-flight reset and per-requester ordering.
module tb_svfloat_itof_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ-1:0]       req_signed = '0;
    logic                  resp_valid;
    logic                  resp_ready = 1'b0;
    logic [31:0]           resp_data;
    logic [1:0]            resp_id;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [NREQ][$];

    svfloat_itof_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_signed (req_signed),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id)
    );

    always #5 clk = ~clk;

    task automatic set_req(input int i, input logic [31:0] d, input logic s);
        req_data[i*WIDTH +: WIDTH] = d;
        req_signed[i] = s;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference conversion through double precision, then round-to-nearest-even down to float32.
    function automatic logic [31:0] ref_itof(input logic [31:0] v, input logic sgn);
        logic        neg;
        longint      m;
        real         r;
        logic [63:0] d;
        logic [22:0] m23;
        logic        g;
        logic        st;
        int          e;
        neg = sgn && v[31];
        m = neg ? (64'sh1_0000_0000 - longint'({32'd0, v})) : longint'({32'd0, v});
        if (m == 0) return 32'h0;
        r   = real'(m);
        d   = $realtobits(r);
        e   = int'(d[62:52]) - 1023 + 127;
        m23 = d[51:29];
        g   = d[28];
        st  = |d[27:0];
        if (g && (st || m23[0])) begin
            m23 = m23 + 23'd1;
            if (m23 == 23'd0) e++;
        end
        return {neg, e[7:0], m23};
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        req_valid = '1;
        resp_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_req_ready: got %b want %b", req_ready, 4'b0000);
        end
        checks++;
        if (resp_valid !== 1'b0 || resp_data !== 32'h0 || resp_id !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got v=%b d=%h id=%0d want v=0 d=0 id=0",
                     resp_valid, resp_data, resp_id);
        end
        rst = 1'b0;
        req_valid = '0;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL idle_req_ready: got %b want %b", req_ready, 4'b0000);
        end
    endtask

    task automatic test_single;
        do_reset();
        resp_ready = 1'b1;
        @(negedge clk);
        set_req(0, 32'd3, 1'b0);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL single_grant: got %b want %b", req_ready, 4'b0001);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_early: got resp_valid=%b want 0", resp_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h40400000 || resp_id !== 2'd0) begin
            errors++;
            $display("[TB] FAIL single_result: got v=%b d=%h id=%0d want v=1 d=40400000 id=0",
                     resp_valid, resp_data, resp_id);
        end
        @(negedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_drain: got resp_valid=%b want 0", resp_valid);
        end
    endtask

    task automatic test_sign;
        int          idx [8]  = '{2, 1, 3, 0, 2, 1, 3, 0};
        logic [31:0] dat [8]  = '{32'hFFFFFFFE, 32'h80000000, 32'h80000000, 32'hFFFFFFFF,
                                  32'h00000000, 32'h01000001, 32'h01000003, 32'hFFFFFFFF};
        logic        sgn [8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] want [8] = '{32'hC0000000, 32'h4F000000, 32'hCF000000, 32'h4F800000,
                                  32'h00000000, 32'h4B800000, 32'h4B800002, 32'hBF800000};
        resp_ready = 1'b1;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            set_req(idx[t], dat[t], sgn[t]);
            req_valid = '0;
            req_valid[idx[t]] = 1'b1;
            #1;
            checks++;
            if (req_ready !== req_valid) begin
                errors++;
                $display("[TB] FAIL sign_grant[%0d]: got %b want %b", t, req_ready, req_valid);
            end
            @(negedge clk);
            req_valid = '0;
            @(negedge clk);
            #1;
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== want[t] || resp_id !== 2'(idx[t])) begin
                errors++;
                $display("[TB] FAIL sign_result[%0d]: got v=%b d=%h id=%0d want v=1 d=%h id=%0d",
                         t, resp_valid, resp_data, resp_id, want[t], idx[t]);
            end
        end
    endtask

    task automatic test_round_robin;
        logic [31:0] rr_exp [4] = '{32'h41200000, 32'h41300000, 32'h41400000, 32'h41500000};
        do_reset();
        resp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 32'(10 + i), 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            req_valid = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (c < 8) begin
                checks++;
                if (req_ready !== 4'(1 << (c % 4))) begin
                    errors++;
                    $display("[TB] FAIL rr_grant[%0d]: got %b want %b", c, req_ready, 4'(1 << (c % 4)));
                end
            end
            if (c >= 2) begin
                checks++;
                if (resp_valid !== 1'b1 || resp_id !== 2'((c - 2) % 4) || resp_data !== rr_exp[(c - 2) % 4]) begin
                    errors++;
                    $display("[TB] FAIL rr_result[%0d]: got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                             c, resp_valid, resp_id, resp_data, (c - 2) % 4, rr_exp[(c - 2) % 4]);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        resp_ready = 1'b0;
        set_req(0, 32'd5, 1'b0);
        set_req(1, 32'd6, 1'b0);
        @(negedge clk);
        req_valid = 4'b0011;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL bp_grant0: got %b want %b", req_ready, 4'b0001);
        end
        @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL bp_grant1: got %b want %b", req_ready, 4'b0010);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (req_ready !== 4'b0000 || resp_valid !== 1'b1 || resp_data !== 32'h40A00000 || resp_id !== 2'd0) begin
                errors++;
                $display("[TB] FAIL bp_full[%0d]: got rdy=%b v=%b d=%h id=%0d want rdy=0000 v=1 d=40a00000 id=0",
                         c, req_ready, resp_valid, resp_data, resp_id);
            end
        end
        @(negedge clk);
        req_valid = '0;
        resp_ready = 1'b1;
        #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h40A00000 || resp_id !== 2'd0) begin
            errors++;
            $display("[TB] FAIL bp_drain0: got v=%b d=%h id=%0d want v=1 d=40a00000 id=0",
                     resp_valid, resp_data, resp_id);
        end
        @(negedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h40C00000 || resp_id !== 2'd1) begin
            errors++;
            $display("[TB] FAIL bp_drain1: got v=%b d=%h id=%0d want v=1 d=40c00000 id=1",
                     resp_valid, resp_data, resp_id);
        end
        @(negedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_empty: got resp_valid=%b want 0", resp_valid);
        end
    endtask

    task automatic test_reset_midflight;
        do_reset();
        resp_ready = 1'b0;
        set_req(0, 32'd7, 1'b0);
        set_req(1, 32'd8, 1'b0);
        set_req(2, 32'd9, 1'b0);
        @(negedge clk);
        req_valid = 4'b0011;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        req_valid = 4'b0110;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL mid_rst_ready: got %b want %b", req_ready, 4'b0000);
        end
        @(negedge clk);
        rst = 1'b0;
        resp_ready = 1'b1;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || resp_data !== 32'h0 || resp_id !== 2'd0) begin
            errors++;
            $display("[TB] FAIL mid_rst_outputs: got v=%b d=%h id=%0d want v=0 d=0 id=0",
                     resp_valid, resp_data, resp_id);
        end
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL mid_rst_first_grant: got %b want %b", req_ready, 4'b0010);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h41000000 || resp_id !== 2'd1) begin
            errors++;
            $display("[TB] FAIL mid_rst_result: got v=%b d=%h id=%0d want v=1 d=41000000 id=1",
                     resp_valid, resp_data, resp_id);
        end
        @(negedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_rst_no_stale: got resp_valid=%b want 0", resp_valid);
        end
    endtask

    task automatic test_random;
        logic [NREQ-1:0] pend;
        logic [NREQ-1:0] acc;
        logic            rfire;
        logic [31:0]     rdat;
        logic [1:0]      rid;
        logic [31:0]     d;
        logic [31:0]     e;
        int              waits [NREQ];
        int              left;
        do_reset();
        pend = '0;
        for (int i = 0; i < NREQ; i++) begin
            waits[i] = 0;
            exp_q[i].delete();
        end
        for (int cyc = 0; cyc < 2040; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (cyc < 2000 && !pend[i] && $urandom_range(0, 2) == 0) begin
                    case ($urandom_range(0, 3))
                        0:       d = 32'($urandom_range(0, 255));
                        1:       d = $urandom;
                        2:       d = {8'h01, 24'($urandom)};
                        default: d = ~32'($urandom_range(0, 255));
                    endcase
                    set_req(i, d, 1'($urandom_range(0, 1)));
                    pend[i] = 1'b1;
                end
            end
            req_valid  = pend;
            resp_ready = (cyc < 2000) ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            acc   = req_ready & req_valid;
            rfire = resp_valid && resp_ready;
            rdat  = resp_data;
            rid   = resp_id;
            checks++;
            if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != '0) begin
                errors++;
                $display("[TB] FAIL rand_ready_shape[%0d]: got rdy=%b valid=%b", cyc, req_ready, req_valid);
            end
            @(posedge clk);
            if (rfire) begin
                checks++;
                if (exp_q[rid].size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rand_unexpected[%0d]: got id=%0d d=%h want no response", cyc, rid, rdat);
                end else begin
                    e = exp_q[rid].pop_front();
                    if (rdat !== e) begin
                        errors++;
                        $display("[TB] FAIL rand_value[%0d]: got id=%0d d=%h want %h", cyc, rid, rdat, e);
                    end
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) begin
                    checks++;
                    if (waits[i] > NREQ - 1) begin
                        errors++;
                        $display("[TB] FAIL rand_fairness[%0d]: got %0d other grants for req %0d want <= %0d",
                                 cyc, waits[i], i, NREQ - 1);
                    end
                    exp_q[i].push_back(ref_itof(req_data[i*WIDTH +: WIDTH], req_signed[i]));
                    pend[i]  = 1'b0;
                    waits[i] = 0;
                end else if (pend[i] && acc != '0) begin
                    waits[i]++;
                end
            end
        end
        req_valid = '0;
        left = 0;
        for (int i = 0; i < NREQ; i++) left += exp_q[i].size();
        checks++;
        if (pend != '0 || left != 0) begin
            errors++;
            $display("[TB] FAIL rand_drain: got pending=%b outstanding=%0d want 0000 and 0", pend, left);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sign();
        test_round_robin();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
